// File: rtl/isqrt_pkg.sv
// Shared types for the integer square-root engine: FSM states, mode codes and
// the control word the controller drives into the datapath.
package isqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    DONE = 2'd3
  } statetype;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_DIGIT  = 1'b1;

  typedef struct packed {
    logic capture;   // latch radicand and mode from the host
    logic load;      // initialise working registers
    logic step_lin;  // one odd-number subtraction step
    logic step_dig;  // one restoring digit step
  } ctrl_t;

endpackage

// File: rtl/isqrt_datapath.sv
// Working registers, comparators and subtractors for both square-root algorithms.
// Result registers are written on the final step and held until the next result.
module isqrt_datapath
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  ctrl_t              ctrl_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   radicand_i,
  output logic               mode_o,
  output logic               last_o,
  output logic [WIDTH/2-1:0] root_o,
  output logic [WIDTH/2:0]   remainder_o
);

  localparam int H  = WIDTH / 2;
  localparam int IW = (H > 2) ? $clog2(H) : 1;
  localparam logic [IW-1:0] IDX_INIT = IW'(H - 1);
  localparam logic [H:0]    ODD_INIT = (H + 1)'(1);
  localparam logic [H:0]    ODD_INC  = (H + 1)'(2);

  logic [WIDTH-1:0] rad_q;
  logic             mode_q;
  logic [WIDTH-1:0] x_q;
  logic [H:0]       odd_q;
  logic [H-1:0]     cnt_q;
  logic [H+1:0]     rem_q;
  logic [H-1:0]     rt_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] sr_q;
  logic [H-1:0]     root_q;
  logic [H:0]       remainder_q;

  logic [WIDTH-1:0] odd_ext;
  logic             lin_ge;
  logic [H+1:0]     r_prime;
  logic [H+1:0]     trial;
  logic             dig_ge;
  logic [H+1:0]     rem_d;
  logic [H-1:0]     rt_d;

  assign odd_ext = {{(WIDTH - H - 1){1'b0}}, odd_q};
  assign lin_ge  = (x_q >= odd_ext);

  // Bring down the next two radicand bits and try the candidate digit 1.
  assign r_prime = (rem_q << 2) | {{H{1'b0}}, sr_q[WIDTH-1 -: 2]};
  assign trial   = {rt_q, 2'b01};
  assign dig_ge  = (r_prime >= trial);
  assign rem_d   = dig_ge ? (r_prime - trial) : r_prime;
  assign rt_d    = (rt_q << 1) | {{(H - 1){1'b0}}, dig_ge};

  assign last_o      = (mode_q == MODE_DIGIT) ? (idx_q == '0) : !lin_ge;
  assign mode_o      = mode_q;
  assign root_o      = root_q;
  assign remainder_o = remainder_q;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      rad_q       <= '0;
      mode_q      <= MODE_LINEAR;
      x_q         <= '0;
      odd_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      rt_q        <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      root_q      <= '0;
      remainder_q <= '0;
    end else begin
      if (ctrl_i.capture) begin
        rad_q  <= radicand_i;
        mode_q <= mode_i;
      end
      if (ctrl_i.load) begin
        x_q   <= rad_q;
        odd_q <= ODD_INIT;
        cnt_q <= '0;
        rem_q <= '0;
        rt_q  <= '0;
        idx_q <= IDX_INIT;
        sr_q  <= rad_q;
      end
      if (ctrl_i.step_lin) begin
        if (lin_ge) begin
          x_q   <= x_q - odd_ext;
          odd_q <= odd_q + ODD_INC;
          cnt_q <= cnt_q + 1'b1;
        end else begin
          root_q      <= cnt_q;
          remainder_q <= x_q[H:0];
        end
      end
      if (ctrl_i.step_dig) begin
        rem_q <= rem_d;
        rt_q  <= rt_d;
        sr_q  <= sr_q << 2;
        idx_q <= idx_q - 1'b1;
        if (idx_q == '0) begin
          root_q      <= rt_d;
          remainder_q <= rem_d[H:0];
        end
      end
    end
  end

endmodule

// File: rtl/isqrt_engine.sv
// Integer square-root engine: start/ready handshake, linear or digit mode, one-cycle
// done pulse; requests arriving outside IDLE are dropped rather than queued.
module isqrt_engine
  import isqrt_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   radicand,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   remainder
);

  statetype state_q, state_d;
  ctrl_t    ctrl;
  logic     mode_q;
  logic     last;

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ctrl.capture = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        ctrl.load = 1'b1;
        state_d   = STEP;
      end
      STEP: begin
        if (mode_q == MODE_DIGIT) ctrl.step_dig = 1'b1;
        else                      ctrl.step_lin = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == LOAD) || (state_q == STEP);
  assign done  = (state_q == DONE);

  isqrt_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock       (clock),
    .reset       (reset),
    .ctrl_i      (ctrl),
    .mode_i      (mode),
    .radicand_i  (radicand),
    .mode_o      (mode_q),
    .last_o      (last),
    .root_o      (root),
    .remainder_o (remainder)
  );

endmodule

// File: tb/tb_isqrt_engine.sv
// Bench for isqrt_engine at WIDTH=16 and WIDTH=8 against a behavioural model.
module tb_isqrt_engine;

  localparam int H0 = 8;
  localparam int H1 = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start0 = 1'b0, mode0 = 1'b0;
  logic [15:0] rad0 = '0;
  logic        ready0, busy0, done0;
  logic [7:0]  root0;
  logic [8:0]  rem0;

  logic        start1 = 1'b0, mode1 = 1'b0;
  logic [7:0]  rad1 = '0;
  logic        ready1, busy1, done1;
  logic [3:0]  root1;
  logic [4:0]  rem1;

  isqrt_engine #(.WIDTH(16)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .mode(mode0), .radicand(rad0),
    .ready(ready0), .busy(busy0), .done(done0), .root(root0), .remainder(rem0)
  );

  isqrt_engine #(.WIDTH(8)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .mode(mode1), .radicand(rad1),
    .ready(ready1), .busy(busy1), .done(done1), .root(root1), .remainder(rem1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, int act_v, int exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic int isqrt_f(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Model: per instance, whether a request is in flight, cycles since acceptance,
  // total latency, pending result and the result currently held on the outputs.
  bit act[2] = '{0, 0};
  int k[2]   = '{0, 0};
  int lat[2] = '{0, 0};
  int er[2]  = '{0, 0};
  int ee[2]  = '{0, 0};
  int hr[2]  = '{0, 0};
  int he[2]  = '{0, 0};

  task automatic model_step(int i, logic s, logic m, int v, int h);
    if (act[i]) begin
      k[i]++;
      if (k[i] > lat[i]) begin
        act[i] = 0;
        hr[i]  = er[i];
        he[i]  = ee[i];
      end
    end else if (s) begin
      act[i] = 1;
      k[i]   = 0;
      er[i]  = isqrt_f(v);
      ee[i]  = v - er[i] * er[i];
      lat[i] = m ? h + 1 : er[i] + 2;
    end
  endtask

  always @(negedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 0; hr[i] = 0; he[i] = 0;
      end
    end else begin
      model_step(0, start0, mode0, int'(rad0), H0);
      model_step(1, start1, mode1, int'(rad1), H1);
    end
  end

  task automatic cmp(int i, logic rdy, logic bsy, logic dn, int rt, int rm);
    int st;
    st = {29'd0, rdy, bsy, dn};
    if (!act[i]) begin
      check($sformatf("idle_status%0d", i), st, 3'b100);
      check($sformatf("held_root%0d", i), rt, hr[i]);
      check($sformatf("held_rem%0d", i), rm, he[i]);
    end else if (k[i] < lat[i]) begin
      check($sformatf("busy_status%0d", i), st, 3'b010);
    end else begin
      check($sformatf("done_status%0d", i), st, 3'b001);
      check($sformatf("done_root%0d", i), rt, er[i]);
      check($sformatf("done_rem%0d", i), rm, ee[i]);
    end
  endtask

  always @(posedge clock) begin
    cmp(0, ready0, busy0, done0, int'(root0), int'(rem0));
    cmp(1, ready1, busy1, done1, int'(root1), int'(rem1));
  end

  function automatic logic get_ready(int i);
    return (i == 0) ? ready0 : ready1;
  endfunction

  function automatic logic get_done(int i);
    return (i == 0) ? done0 : done1;
  endfunction

  function automatic int get_root(int i);
    return (i == 0) ? int'(root0) : int'(root1);
  endfunction

  function automatic int get_rem(int i);
    return (i == 0) ? int'(rem0) : int'(rem1);
  endfunction

  task automatic drive(int i, logic s, logic m, int v);
    if (i == 0) begin
      start0 = s; mode0 = m; rad0 = v[15:0];
    end else begin
      start1 = s; mode1 = m; rad1 = v[7:0];
    end
  endtask

  task automatic wait_ready(int i);
    int t = 0;
    @(posedge clock);
    while (!get_ready(i) && t < 600) begin
      @(posedge clock);
      t++;
    end
    if (t >= 600) check($sformatf("ready_timeout%0d", i), 0, 1);
  endtask

  // One request; inj >= 0 re-asserts start (radicand 100) after edge inj.
  task automatic run_one(int i, logic m, int v, int exp_r, int exp_e, int exp_lat, int inj);
    int e = 0;
    wait_ready(i);
    @(negedge clock); #1;
    drive(i, 1'b1, m, v);
    @(negedge clock); #1;
    drive(i, 1'b0, ~m, int'($urandom));
    forever begin
      @(posedge clock);
      if (get_done(i) || e >= 600) break;
      @(negedge clock);
      e++;
      #1;
      if (e == inj) drive(i, 1'b1, ~m, 100);
      else          drive(i, 1'b0, $urandom_range(0, 1), int'($urandom));
    end
    if (e >= 600) begin
      check($sformatf("done_timeout_v%0d", v), 0, 1);
      return;
    end
    check($sformatf("lat_v%0d_m%0d", v, m), e, exp_lat);
    check($sformatf("root_v%0d_m%0d", v, m), get_root(i), exp_r);
    check($sformatf("rem_v%0d_m%0d", v, m), get_rem(i), exp_e);
    @(negedge clock); #1;
    drive(i, 1'b0, m, 0);
    @(posedge clock);
    check($sformatf("ready_after_done_v%0d", v), int'(get_ready(i)), 1);
  endtask

  initial begin
    #12;
    reset = 1'b1;

    run_one(0, 1'b0,    50,   7,   1,   9, -1);
    run_one(0, 1'b1,    50,   7,   1,   9, -1);
    run_one(0, 1'b0, 65535, 255, 510, 257, -1);
    run_one(0, 1'b1, 65535, 255, 510,   9, -1);
    run_one(0, 1'b0,     0,   0,   0,   2, -1);
    run_one(0, 1'b1,     0,   0,   0,   9, -1);
    run_one(0, 1'b0,    50,   7,   1,   9,  4);
    run_one(0, 1'b1,    50,   7,   1,   9,  9);
    run_one(0, 1'b1, 65535, 255, 510,   9, -1);

    // Reset in the middle of a long linear run.
    wait_ready(0);
    @(negedge clock); #1;
    drive(0, 1'b1, 1'b0, 40000);
    @(negedge clock); #1;
    drive(0, 1'b0, 1'b0, 0);
    repeat (20) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_ready", int'(ready0), 1);
    check("rst_busy", int'(busy0), 0);
    check("rst_root", int'(root0), 0);
    check("rst_rem", int'(rem0), 0);
    @(negedge clock); #1;
    reset = 1'b1;
    run_one(0, 1'b0, 144, 12, 0, 14, -1);

    run_one(1, 1'b1, 200, 14,  4,  5, -1);
    run_one(1, 1'b1, 255, 15, 30,  5, -1);
    run_one(1, 1'b0, 255, 15, 30, 17, -1);

    // Free-running random traffic on both instances, with one reset pulse.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock); #1;
      reset = (c != 1500);
      drive(0, ($urandom % 3) == 0, $urandom_range(0, 1),
            ($urandom % 4 == 0) ? int'($urandom % 65536) : int'($urandom % 1024));
      drive(1, ($urandom % 3) == 0, $urandom_range(0, 1), int'($urandom % 256));
    end
    @(negedge clock); #1;
    drive(0, 1'b0, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 0);
    begin
      int t = 0;
      while ((act[0] || act[1]) && t < 600) begin
        @(posedge clock);
        t++;
      end
      if (t >= 600) check("drain_timeout", 0, 1);
    end
    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
